// File: rtl/line_window_gen_if.sv
// Pixel-in / window-out bundle for line_window_gen.
//   master: pixel source and window sink (drives in_valid/in_sol/in_eol/in_pixel)
//   slave : the window generator (drives in_ready and all out_* signals)
//   in_valid/in_ready  accept handshake; in_sol/in_eol  line tags on the pixel
//   out_valid          one-cycle window strobe, no backpressure
//   out_sol/out_eol    window is the first/last x of its line
//   out_vals[k]        pixel at x-RADIUS+k, zero-extended to PIX_BITW+1 bits
interface line_window_gen_if #(
  parameter int unsigned RADIUS   = 2,
  parameter int unsigned PIX_BITW = 8
);
  localparam int unsigned WIN      = 2 * RADIUS + 1;
  localparam int unsigned OUT_BITW = PIX_BITW + 1;

  logic                          in_valid;
  logic                          in_ready;
  logic                          in_sol;
  logic                          in_eol;
  logic [PIX_BITW-1:0]           in_pixel;
  logic                          out_valid;
  logic                          out_sol;
  logic                          out_eol;
  logic [0:WIN-1][OUT_BITW-1:0]  out_vals;

  modport master (
    output in_valid, in_sol, in_eol, in_pixel,
    input  in_ready, out_valid, out_sol, out_eol, out_vals
  );

  modport slave (
    input  in_valid, in_sol, in_eol, in_pixel,
    output in_ready, out_valid, out_sol, out_eol, out_vals
  );
endinterface

// File: rtl/line_window_gen.sv
// Turns a raster pixel stream into a horizontal window of 2*RADIUS+1 pixels
// centred on each pixel, replicating edge pixels at line borders. Feeds the
// adder-tree filters; exactly one window is emitted per input pixel.
// Ports:
//   clock  clock
//   reset  asynchronous, active-high reset
//   bus    line_window_gen_if.slave (pixel handshake in, window strobe out)
module line_window_gen #(
  parameter int unsigned RADIUS   = 2,
  parameter int unsigned PIX_BITW = 8
) (
  input  logic             clock,
  input  logic             reset,
  line_window_gen_if.slave bus
);
  localparam int unsigned WIN      = 2 * RADIUS + 1;
  localparam int unsigned OUT_BITW = PIX_BITW + 1;
  // cnt reaches RADIUS, and cnt+2 must not wrap
  localparam int unsigned CNT_W    = $clog2(RADIUS + 3);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                        state;
  logic [0:WIN-1][OUT_BITW-1:0]  taps;
  logic [CNT_W-1:0]              cnt;
  logic [CNT_W-1:0]              fcnt;
  logic                          sol_pending;

  logic                          accept;
  logic [OUT_BITW-1:0]           pix_ext;
  logic [CNT_W-1:0]              cnt_inc;
  logic [CNT_W-1:0]              cnt_inc2;

  assign bus.in_ready = (state != FLUSH);
  assign accept       = bus.in_valid && bus.in_ready;
  assign pix_ext      = OUT_BITW'(bus.in_pixel);
  assign cnt_inc      = cnt + CNT_W'(1);
  assign cnt_inc2     = cnt + CNT_W'(2);
  assign bus.out_vals = taps;

  // Window state machine, tap shift register and registered strobes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      taps          <= '0;
      cnt           <= '0;
      fcnt          <= '0;
      sol_pending   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_sol   <= 1'b0;
      bus.out_eol   <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.out_sol   <= 1'b0;
      bus.out_eol   <= 1'b0;
      case (state)
        FLUSH: begin
          // Right-edge replicate: recirculate the newest pixel
          taps          <= {taps[1:WIN-1], taps[WIN-1]};
          bus.out_valid <= 1'b1;
          bus.out_sol   <= sol_pending;
          sol_pending   <= 1'b0;
          bus.out_eol   <= (fcnt == CNT_W'(1));
          fcnt          <= fcnt - CNT_W'(1);
          if (fcnt == CNT_W'(1)) begin
            state <= IDLE;
          end
        end
        default: begin
          if (accept) begin
            if (bus.in_sol) begin
              // Left-edge replicate; any unfinished previous line is abandoned
              taps        <= {WIN{pix_ext}};
              cnt         <= '0;
              sol_pending <= 1'b1;
              if (bus.in_eol) begin
                state <= FLUSH;
                fcnt  <= CNT_W'(1);
              end else begin
                state <= RUN;
              end
            end else if (state == RUN) begin
              taps <= {taps[1:WIN-1], pix_ext};
              if (cnt_inc >= CNT_W'(RADIUS)) begin
                bus.out_valid <= 1'b1;
                bus.out_sol   <= (cnt_inc == CNT_W'(RADIUS));
                sol_pending   <= 1'b0;
              end
              if (cnt != CNT_W'(RADIUS)) begin
                cnt <= cnt_inc;
              end
              if (bus.in_eol) begin
                // Windows still owed = min(line width, RADIUS); width = cnt+2
                state <= FLUSH;
                fcnt  <= (cnt_inc2 >= CNT_W'(RADIUS)) ? CNT_W'(RADIUS) : cnt_inc2;
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_line_window_gen.sv
// Bench for line_window_gen: one RADIUS=1 and one RADIUS=2 instance, each fed
// lines of pixels; expected windows (values, tags, due cycle) are queued as
// pixels are accepted and compared when the window is due.
module tb_line_window_gen;
  localparam int unsigned PIX_BITW = 8;
  localparam int unsigned OUT_BITW = PIX_BITW + 1;

  typedef struct {
    logic [63:0] vals;
    logic        sol;
    logic        eol;
    int          due;
  } exp_t;

  logic clock = 1'b0;
  logic reset1;
  logic reset2;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy1 = 0;
  int   busy2 = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  line_window_gen_if #(.RADIUS(1), .PIX_BITW(PIX_BITW)) bus1 ();
  line_window_gen_if #(.RADIUS(2), .PIX_BITW(PIX_BITW)) bus2 ();

  line_window_gen #(.RADIUS(1), .PIX_BITW(PIX_BITW)) dut1 (
    .clock (clock),
    .reset (reset1),
    .bus   (bus1)
  );

  line_window_gen #(.RADIUS(2), .PIX_BITW(PIX_BITW)) dut2 (
    .clock (clock),
    .reset (reset2),
    .bus   (bus2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Expected window centred on x, edge-clamped, flattened with tap 0 in the MSBs
  function automatic logic [63:0] win_flat(input int px[$], input int x, input int r);
    logic [63:0] f;
    int          i;
    f = '0;
    for (int k = 0; k < 2 * r + 1; k++) begin
      i = x - r + k;
      if (i < 0) i = 0;
      if (i > px.size() - 1) i = px.size() - 1;
      f = (f << OUT_BITW) | 64'(px[i]);
    end
    return f;
  endfunction

  always @(negedge clock) begin
    if (!bus1.in_ready) busy1++;
    if (!bus2.in_ready) busy2++;
  end

  always @(negedge clock) begin
    if (q1.size() > 0 && q1[0].due == cyc) begin
      check("r1_valid", 64'(bus1.out_valid), 64'(1));
      check("r1_vals", 64'(bus1.out_vals), q1[0].vals);
      check("r1_sol", 64'(bus1.out_sol), 64'(q1[0].sol));
      check("r1_eol", 64'(bus1.out_eol), 64'(q1[0].eol));
      void'(q1.pop_front());
    end else begin
      check("r1_idle", 64'(bus1.out_valid), 64'(0));
    end
  end

  always @(negedge clock) begin
    if (q2.size() > 0 && q2[0].due == cyc) begin
      check("r2_valid", 64'(bus2.out_valid), 64'(1));
      check("r2_vals", 64'(bus2.out_vals), q2[0].vals);
      check("r2_sol", 64'(bus2.out_sol), 64'(q2[0].sol));
      check("r2_eol", 64'(bus2.out_eol), 64'(q2[0].eol));
      void'(q2.pop_front());
    end else begin
      check("r2_idle", 64'(bus2.out_valid), 64'(0));
    end
  end

  task automatic set_in(input int d, input bit v, input bit sol, input bit eol, input int pix);
    if (d == 1) begin
      bus1.in_valid = v; bus1.in_sol = sol; bus1.in_eol = eol; bus1.in_pixel = PIX_BITW'(pix);
    end else begin
      bus2.in_valid = v; bus2.in_sol = sol; bus2.in_eol = eol; bus2.in_pixel = PIX_BITW'(pix);
    end
  endtask

  function automatic bit rdy(input int d);
    return (d == 1) ? bus1.in_ready : bus2.in_ready;
  endfunction

  function automatic int qsize(input int d);
    return (d == 1) ? q1.size() : q2.size();
  endfunction

  function automatic void push(input int d, input exp_t e);
    if (d == 1) q1.push_back(e);
    else q2.push_back(e);
  endfunction

  // Called at a negedge; returns with the pixel set up to be accepted on the next posedge
  task automatic send(input int d, input int pix, input bit sol, input bit eol, output int acc);
    int t;
    t = 0;
    set_in(d, 1'b1, sol, eol, pix);
    while (!rdy(d) && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) check("ready_timeout", 64'(0), 64'(1));
    acc = cyc + 1;
  endtask

  task automatic drive_line(input int d, input int px[$], input bit has_eol,
                            input bit gaps, input bit abort);
    int   r, w, nrun, acc, b0, t, g;
    exp_t e;
    r    = (d == 1) ? 1 : 2;
    w    = px.size();
    nrun = (w > r) ? w - r : 0;
    b0   = (d == 1) ? busy1 : busy2;
    for (int x = 0; x < w; x++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        set_in(d, 1'b0, 1'b0, 1'b0, 0);
        repeat (g) @(negedge clock);
      end
      send(d, px[x], x == 0, has_eol && (x == w - 1), acc);
      if (x >= r && (x - r) < nrun) begin
        e.vals = win_flat(px, x - r, r);
        e.sol  = (x - r == 0);
        e.eol  = 1'b0;
        e.due  = acc;
        push(d, e);
      end
      if (has_eol && x == w - 1) begin
        for (int j = nrun; j < w; j++) begin
          e.vals = win_flat(px, j, r);
          e.sol  = (j == 0);
          e.eol  = (j == w - 1);
          e.due  = acc + j - nrun + 1;
          push(d, e);
        end
      end
      @(negedge clock);
    end
    set_in(d, 1'b0, 1'b0, 1'b0, 0);
    if (abort) begin
      // One flush window has been checked; reset before the rest come out
      @(negedge clock);
      #1;
      reset2 = 1'b1;
      q2.delete();
      #1;
      check("abort_valid", 64'(bus2.out_valid), 64'(0));
      check("abort_sol", 64'(bus2.out_sol), 64'(0));
      check("abort_eol", 64'(bus2.out_eol), 64'(0));
      check("abort_ready", 64'(bus2.in_ready), 64'(1));
      check("abort_vals", 64'(bus2.out_vals), 64'(0));
      @(negedge clock);
      reset2 = 1'b0;
    end else begin
      t = 0;
      while (qsize(d) > 0 && t < 100) begin
        @(negedge clock);
        t++;
      end
      if (t >= 100) check("drain_timeout", 64'(0), 64'(1));
      @(negedge clock);
      check("busy_cycles", 64'(((d == 1) ? busy1 : busy2) - b0),
            64'(has_eol ? ((w < r) ? w : r) : 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int line[$];
    int acc;
    reset1 = 1'b1;
    reset2 = 1'b1;
    set_in(1, 1'b0, 1'b0, 1'b0, 0);
    set_in(2, 1'b0, 1'b0, 1'b0, 0);
    repeat (2) @(negedge clock);
    check("rst_ready1", 64'(bus1.in_ready), 64'(1));
    check("rst_ready2", 64'(bus2.in_ready), 64'(1));
    check("rst_vals1", 64'(bus1.out_vals), 64'(0));
    check("rst_vals2", 64'(bus2.out_vals), 64'(0));
    check("rst_tags2", 64'({bus2.out_sol, bus2.out_eol}), 64'(0));
    reset1 = 1'b0;
    reset2 = 1'b0;
    @(negedge clock);

    // Pixel without sol while idle is dropped
    send(2, 99, 1'b0, 1'b0, acc);
    @(negedge clock);
    set_in(2, 1'b0, 1'b0, 1'b0, 0);
    repeat (3) @(negedge clock);
    check("drop_vals", 64'(bus2.out_vals), 64'(0));

    line = '{10, 20, 30, 40};
    drive_line(1, line, 1'b1, 1'b0, 1'b0);
    line = '{7};
    drive_line(2, line, 1'b1, 1'b0, 1'b0);
    line = '{5, 9};
    drive_line(2, line, 1'b1, 1'b0, 1'b0);
    line = '{};
    for (int i = 1; i <= 6; i++) line.push_back(i);
    drive_line(1, line, 1'b1, 1'b1, 1'b0);
    line = '{3};
    drive_line(1, line, 1'b1, 1'b0, 1'b0);
    line = '{4, 6};
    drive_line(1, line, 1'b1, 1'b1, 1'b0);

    // Line abandoned by a new sol after three pixels
    line = '{11, 12, 13};
    drive_line(2, line, 1'b0, 1'b0, 1'b0);
    line = '{21, 22, 23, 24, 25, 26};
    drive_line(2, line, 1'b1, 1'b1, 1'b0);

    // Reset during flush, then a clean line
    line = '{31, 32, 33};
    drive_line(2, line, 1'b1, 1'b0, 1'b1);
    line = '{41, 42, 43};
    drive_line(2, line, 1'b1, 1'b0, 1'b0);

    // Full-scale pixels stay positive after zero-extension
    line = '{255};
    drive_line(2, line, 1'b1, 1'b0, 1'b0);
    line = '{255, 0, 128};
    drive_line(1, line, 1'b1, 1'b1, 1'b0);

    repeat (3) @(negedge clock);
    check("q1_empty", 64'(q1.size()), 64'(0));
    check("q2_empty", 64'(q2.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
